// File: rtl/sla_sequential.sv
// Sequential arithmetic left shifter: shifts a signed operand one bit per clock with sticky overflow detection.
// Optional build macro SLA_SATURATE_EN clamps the result to the signed max/min on overflow.
module sla_sequential #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Input1,
  input  logic [WIDTH-1:0] Input2,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Done,
  output logic             Overflow,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAXN   = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    MAXN_C = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Handshake: Start is taken only at a rising edge seen in S_IDLE; Busy spans accept..completion,
  // and Done is a one-cycle pulse that coincides with Result/Overflow becoming valid.
  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_sign;

  logic             w_clamp;
  logic [CW-1:0]    w_n;
  logic [WIDTH-1:0] w_sat;

  assign w_clamp     = (Input2 >= MAXN);
  assign w_n         = w_clamp ? MAXN_C : CW'(Input2);
  assign w_sat       = r_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_sign   <= 1'b0;
      Result   <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            r_acc   <= Input1;
            r_sign  <= Input1[WIDTH-1];
            r_cnt   <= w_n;
            r_ovf   <= 1'b0;
            Busy    <= 1'b1;
            r_state <= (w_n == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          // A sign change before the shift means the true product leaves the signed range.
          if (r_acc[WIDTH-1] != r_acc[WIDTH-2]) r_ovf <= 1'b1;
          r_acc <= r_acc << 1;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_DONE;
        end
        S_DONE: begin
`ifdef SLA_SATURATE_EN
          Result <= r_ovf ? w_sat : r_acc;
`else
          Result <= r_acc;
`endif
          Overflow <= r_ovf;
          Done     <= 1'b1;
          Busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sla_sequential.sv
// Bench for sla_sequential: directed operations with hand-computed results, scoreboard queue
// checked by an independent monitor on every Done pulse.
module tb_sla_sequential;
  localparam int W = 8;

  logic         clk;
  logic         Reset_n;
  logic         Start;
  logic [W-1:0] Input1;
  logic [W-1:0] Input2;
  logic [W-1:0] Result;
  logic         Busy;
  logic         Done;
  logic         Overflow;
  logic [1:0]   o_dbg_state;

  int checks;
  int failures;
  logic [W:0] exp_q[$];

  sla_sequential #(.WIDTH(W)) dut (
    .clk(clk), .Reset_n(Reset_n), .Start(Start), .Input1(Input1), .Input2(Input2),
    .Result(Result), .Busy(Busy), .Done(Done), .Overflow(Overflow), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (Reset_n && Done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=Result:%0h expected=no_done", Result);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("result", {24'd0, Result}, {24'd0, e[W-1:0]});
        check("overflow", {31'd0, Overflow}, {31'd0, e[W]});
      end
    end
  end

  // driver: issue one operation, measure latency and Busy duration
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic eo, input int elat,
                       input bit repulse);
    int lat;
    int busy;
    @(negedge clk);
    Input1 = a;
    Input2 = b;
    Start  = 1'b1;
    exp_q.push_back({eo, er});
    @(posedge clk);
    #1;
    Start  = 1'b0;
    Input1 = W'($urandom_range(0, 255));
    Input2 = W'($urandom_range(0, 255));
    lat  = 0;
    busy = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (Done) break;
      if (Busy) busy++;
      if (repulse && busy == 2) begin
        Start  = 1'b1;
        Input1 = 8'h11;
        Input2 = 8'h00;
      end else begin
        Start = 1'b0;
      end
      @(posedge clk);
      lat++;
    end
    Start = 1'b0;
    check("latency", lat, elat);
    check("busy_cycles", busy, elat);
    check("busy_at_done", {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset_n  = 1'b0;
    Start    = 1'b0;
    Input1   = '0;
    Input2   = '0;
    #1;
    check("reset_result", {24'd0, Result}, 32'd0);
    check("reset_flags", {29'd0, Busy, Done, Overflow}, 32'd0);
    check("reset_state", {30'd0, o_dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    Reset_n = 1'b1;

    do_op(8'h03, 8'd4,   8'h30, 1'b0, 5, 1'b0);
    do_op(8'hFD, 8'd2,   8'hF4, 1'b0, 3, 1'b0);
`ifdef SLA_SATURATE_EN
    do_op(8'h40, 8'd1,   8'h7F, 1'b1, 2, 1'b0);
    do_op(8'hFF, 8'd200, 8'h80, 1'b1, 9, 1'b0);
    do_op(8'h81, 8'd1,   8'h80, 1'b1, 2, 1'b0);
    do_op(8'h7F, 8'd8,   8'h7F, 1'b1, 9, 1'b0);
    do_op(8'h01, 8'd7,   8'h7F, 1'b1, 8, 1'b0);
    do_op(8'h03, 8'd9,   8'h7F, 1'b1, 9, 1'b0);
`else
    do_op(8'h40, 8'd1,   8'h80, 1'b1, 2, 1'b0);
    do_op(8'hFF, 8'd200, 8'h00, 1'b1, 9, 1'b0);
    do_op(8'h81, 8'd1,   8'h02, 1'b1, 2, 1'b0);
    do_op(8'h7F, 8'd8,   8'h00, 1'b1, 9, 1'b0);
    do_op(8'h01, 8'd7,   8'h80, 1'b1, 8, 1'b0);
    do_op(8'h03, 8'd9,   8'h00, 1'b1, 9, 1'b0);
`endif
    do_op(8'h5A, 8'd0,   8'h5A, 1'b0, 1, 1'b0);
    do_op(8'h00, 8'd8,   8'h00, 1'b0, 9, 1'b0);
    do_op(8'h80, 8'd0,   8'h80, 1'b0, 1, 1'b0);
    do_op(8'hFF, 8'd7,   8'h80, 1'b0, 8, 1'b0);
    do_op(8'h01, 8'd6,   8'h40, 1'b0, 7, 1'b0);
    do_op(8'h05, 8'd3,   8'h28, 1'b0, 4, 1'b1);

    // abort mid-shift: no Done may follow, outputs clear immediately
    @(negedge clk);
    Input1 = 8'h40;
    Input2 = 8'd6;
    Start  = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    repeat (3) @(posedge clk);
    #2 Reset_n = 1'b0;
    #1;
    check("abort_result", {24'd0, Result}, 32'd0);
    check("abort_flags", {29'd0, Busy, Done, Overflow}, 32'd0);
    check("abort_state", {30'd0, o_dbg_state}, 32'd0);
    repeat (3) @(negedge clk);
    Reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_idle", {30'd0, o_dbg_state}, 32'd0);

    do_op(8'h03, 8'd4, 8'h30, 1'b0, 5, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sla_sequential.md
SLA_SEQUENTIAL -- requirements
Module: sla_sequential

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (>=2).
REQ-002 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port: Reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: Start  input  1  request to begin a shift; sampled on clk rising edge.
REQ-005 SHALL have port: Input1  input  WIDTH  signed two's-complement operand.
REQ-006 SHALL have port: Input2  input  WIDTH  unsigned left-shift amount.
REQ-007 SHALL have port: Result  output  WIDTH  registered signed result, held until the next completion.
REQ-008 SHALL have port: Busy  output  1  high from operation accept until completion.
REQ-009 SHALL have port: Done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: Overflow  output  1  true product Input1*2^n not representable in WIDTH signed bits; held with Result.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE, shifting one bit per clock.
REQ-012 SHALL accept Start only in IDLE; Start in SHIFT or DONE SHALL be ignored, with no restart and no queuing.
REQ-013 On the accept edge E0, SHALL latch Input1 into the accumulator and n = min(Input2, WIDTH) into the counter, clear the internal overflow flag, and set Busy=1.
REQ-014 At E0, SHALL go to SHIFT if n>0 and to DONE if n=0.
REQ-015 At each SHIFT edge, SHALL set sticky overflow if acc[WIDTH-1]!=acc[WIDTH-2], then acc<=acc<<1 (zero fill) and decrement the counter.
REQ-016 On the edge performing the n-th shift (En), SHALL go to DONE.
REQ-017 At the DONE edge (E(n+1)), SHALL update Result and Overflow, set Done=1 and Busy=0, and return to IDLE; Done SHALL drop on the following edge.
REQ-018 Total latency SHALL be n+1 clock edges from the accept edge to the Done rising edge.
REQ-019 Input2 >= WIDTH SHALL clamp to WIDTH: result 0, or saturated if enabled; Overflow=1 iff Input1!=0.
REQ-020 Input1 and Input2 changes after E0 SHALL NOT affect the operation in flight.
REQ-021 Result and Overflow SHALL change only at a DONE edge or at reset.
REQ-022 A new Start SHALL NOT be accepted in the same cycle Done is high, because the FSM is still leaving DONE; the earliest accept is the edge after the Done edge.

Reset
REQ-023 Reset_n=0 SHALL immediately force state=IDLE, Result=0, Busy=0, Done=0, Overflow=0, and clear the accumulator and counter, including mid-operation.
REQ-024 The aborted operation SHALL produce no Done; the first Start after reset release SHALL be accepted normally.

Configuration
REQ-025 Macro SLA_SATURATE_EN defined: on overflow, Result SHALL be the maximum positive value (0x7F for WIDTH=8) if the latched Input1 was non-negative, else the minimum value (0x80).
REQ-026 Macro SLA_SATURATE_EN undefined: Result SHALL be the wrapped low WIDTH bits of the shifted value; Overflow behaviour SHALL be identical in both builds.

Verification
REQ-027 Input1=3, Input2=4, Start pulse -> Busy for 5 cycles, Done one cycle, Result=0x30, Overflow=0.
REQ-028 Input1=0xFD (-3), Input2=2 -> Result=0xF4 (-12), Overflow=0, Done 3 edges after accept.
REQ-029 Input1=0x40, Input2=1 -> Overflow=1; Result=0x80 without SLA_SATURATE_EN, 0x7F with it; Input1=0xFF, Input2=200 -> clamped, Overflow=1, Result 0x00 or 0x80.
REQ-030 Input2=0 -> Done 1 edge after accept, Result=Input1, Overflow=0; Input1=0, Input2=8 -> Result=0, Overflow=0.
REQ-031 Start re-pulsed mid-SHIFT with new operands -> ignored; the first operation's result is unchanged.
REQ-032 Reset_n low during SHIFT -> all outputs 0 asynchronously with no Done; next Start Input1=3, Input2=4 -> Result=0x30.
